// File: rtl/ani_sequencer.sv
// ani_sequencer
//   Steps a frame counter through the current animation at a prescaled tick
//   rate. Buttons select the next or previous animation. With auto_en set,
//   the sequencer moves to the next animation each time the frame wraps.
//
// Parameters
//   TICK_DIV  : tick strobes per frame step (1..256)
//   START_ANI : animation index loaded at reset (0..63)
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : synchronous reset, active-low
//   tick      : one-cycle frame-rate strobe
//   limit     : frame count of the current animation (0 means 32); driven
//               combinationally from `animation`
//   next_btn  : debounced level; a rising edge selects the next animation
//   prev_btn  : debounced level; a rising edge selects the previous animation
//   auto_en   : advance the animation automatically at each wrap
//   pause_btn : (only with ANI_SEQUENCER_PAUSE_EN) a rising edge toggles pause
//   animation : current animation index
//   frame     : current frame within the animation
//   step      : one-cycle pulse after a tick-driven frame change
//   wrap      : one-cycle pulse after the frame returns from last to 0
//
// Optional feature: define ANI_SEQUENCER_PAUSE_EN to add pause_btn.

module ani_sequencer #(
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned START_ANI = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [4:0] limit,
  input  logic       next_btn,
  input  logic       prev_btn,
  input  logic       auto_en,
`ifdef ANI_SEQUENCER_PAUSE_EN
  input  logic       pause_btn,
`endif
  output logic [5:0] animation,
  output logic [4:0] frame,
  output logic       step,
  output logic       wrap
);

  localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);
  localparam logic [5:0] ANI_RST  = 6'(START_ANI);

  logic [5:0] r_animation, w_animation_nxt;
  logic [4:0] r_frame,     w_frame_nxt;
  logic [7:0] r_div_cnt,   w_div_cnt_nxt;
  logic       r_step,      w_step_nxt;
  logic       r_wrap,      w_wrap_nxt;
  logic       r_next_q, r_prev_q;
  // Low for the first cycle after reset. Edges are masked while it is low,
  // so a button that is held through reset release does not produce an edge.
  logic       r_armed;

  logic [5:0] w_len;
  logic       w_at_last;
  logic       w_next_edge, w_prev_edge, w_btn_accept;
  logic       w_tick_en;
  logic       w_paused;

`ifdef ANI_SEQUENCER_PAUSE_EN
  logic r_pause_q, r_paused;
  logic w_pause_edge;

  assign w_pause_edge = r_armed & pause_btn & ~r_pause_q;
  assign w_paused     = r_paused;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pause_q <= 1'b0;
      r_paused  <= 1'b0;
    end else begin
      r_pause_q <= pause_btn;
      if (w_pause_edge) r_paused <= ~r_paused;
    end
  end
`else
  assign w_paused = 1'b0;
`endif

  assign w_next_edge  = r_armed & next_btn & ~r_next_q;
  assign w_prev_edge  = r_armed & prev_btn & ~r_prev_q;
  // Coincident next and prev edges cancel each other.
  assign w_btn_accept = w_next_edge ^ w_prev_edge;
  assign w_tick_en    = tick & ~w_paused;

  always_comb begin
    w_len     = (limit == 5'd0) ? 6'd32 : {1'b0, limit};
    // Use >= rather than == so that a frame already past a shorter new
    // limit still wraps.
    w_at_last = ({1'b0, r_frame} >= (w_len - 6'd1));

    w_animation_nxt = r_animation;
    w_frame_nxt     = r_frame;
    w_div_cnt_nxt   = r_div_cnt;
    w_step_nxt      = 1'b0;
    w_wrap_nxt      = 1'b0;

    if (w_btn_accept) begin
      w_animation_nxt = w_next_edge ? (r_animation + 6'd1) : (r_animation - 6'd1);
      w_frame_nxt     = '0;
      w_div_cnt_nxt   = '0;
    end else if (w_tick_en) begin
      if (r_div_cnt == DIV_LAST) begin
        w_div_cnt_nxt = '0;
        w_step_nxt    = 1'b1;
        if (w_at_last) begin
          w_frame_nxt = '0;
          w_wrap_nxt  = 1'b1;
          if (auto_en) w_animation_nxt = r_animation + 6'd1;
        end else begin
          w_frame_nxt = r_frame + 5'd1;
        end
      end else begin
        w_div_cnt_nxt = r_div_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_animation <= ANI_RST;
      r_frame     <= '0;
      r_div_cnt   <= '0;
      r_step      <= 1'b0;
      r_wrap      <= 1'b0;
      r_next_q    <= 1'b0;
      r_prev_q    <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_animation <= w_animation_nxt;
      r_frame     <= w_frame_nxt;
      r_div_cnt   <= w_div_cnt_nxt;
      r_step      <= w_step_nxt;
      r_wrap      <= w_wrap_nxt;
      r_next_q    <= next_btn;
      r_prev_q    <= prev_btn;
      r_armed     <= 1'b1;
    end
  end

  assign animation = r_animation;
  assign frame     = r_frame;
  assign step      = r_step;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_ani_sequencer.sv
// Testbench for ani_sequencer. Two instances run side by side on shared
// stimulus:
//   - one with TICK_DIV=1, START_ANI=0
//   - one with TICK_DIV=4, START_ANI=5
// Each instance has its own limit source, which is either a fixed value or
// a lookup driven from that instance's animation output.
module tb_ani_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, tick, next_btn, prev_btn, auto_en;
  logic [4:0] lim_fix;
  bit         lim_mode;
  logic [4:0] limit1, limit4;
  logic [5:0] anim1, anim4;
  logic [4:0] frame1, frame4;
  logic       step1, step4, wrap1, wrap4;
`ifdef ANI_SEQUENCER_PAUSE_EN
  logic       pause_btn;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [4:0] lut(input logic [5:0] a);
    int v;
    v = (int'(a) * 7 + 3) % 32;
    return 5'(v);
  endfunction

  assign limit1 = lim_mode ? lut(anim1) : lim_fix;
  assign limit4 = lim_mode ? lut(anim4) : lim_fix;

  ani_sequencer #(.TICK_DIV(1), .START_ANI(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .limit(limit1),
    .next_btn(next_btn), .prev_btn(prev_btn), .auto_en(auto_en),
`ifdef ANI_SEQUENCER_PAUSE_EN
    .pause_btn(pause_btn),
`endif
    .animation(anim1), .frame(frame1), .step(step1), .wrap(wrap1)
  );

  ani_sequencer #(.TICK_DIV(4), .START_ANI(5)) dut4 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .limit(limit4),
    .next_btn(next_btn), .prev_btn(prev_btn), .auto_en(auto_en),
`ifdef ANI_SEQUENCER_PAUSE_EN
    .pause_btn(pause_btn),
`endif
    .animation(anim4), .frame(frame4), .step(step4), .wrap(wrap4)
  );

  // Reference model, computed from the rules directly.
  int m_anim[2], m_frame[2], m_cnt[2], m_step[2], m_wrap[2];
  int m_div[2]   = '{1, 4};
  int m_start[2] = '{0, 5};
  bit m_nq, m_pq, m_paq, m_paused, m_after_rst;

  task automatic model_update(input bit r, input bit t, input bit nb,
                              input bit pb, input bit pa);
    bit ne, pe, pae, tick_ok;
    int lim, len;
    if (!r) begin
      for (int i = 0; i < 2; i++) begin
        m_anim[i] = m_start[i];
        m_frame[i] = 0;
        m_cnt[i] = 0;
        m_step[i] = 0;
        m_wrap[i] = 0;
      end
      m_nq = 0; m_pq = 0; m_paq = 0; m_paused = 0; m_after_rst = 1;
      return;
    end
    ne  = nb && !m_nq && !m_after_rst;
    pe  = pb && !m_pq && !m_after_rst;
    pae = pa && !m_paq && !m_after_rst;
    tick_ok = t && !m_paused;
    for (int i = 0; i < 2; i++) begin
      lim = lim_mode ? int'(lut(6'(m_anim[i]))) : int'(lim_fix);
      len = (lim == 0) ? 32 : lim;
      m_step[i] = 0;
      m_wrap[i] = 0;
      if (ne != pe) begin
        m_anim[i]  = (m_anim[i] + (ne ? 1 : 63)) % 64;
        m_frame[i] = 0;
        m_cnt[i]   = 0;
      end else if (tick_ok) begin
        m_cnt[i]++;
        if (m_cnt[i] == m_div[i]) begin
          m_cnt[i]  = 0;
          m_step[i] = 1;
          if (m_frame[i] >= len - 1) begin
            m_frame[i] = 0;
            m_wrap[i]  = 1;
            if (auto_en) m_anim[i] = (m_anim[i] + 1) % 64;
          end else begin
            m_frame[i]++;
          end
        end
      end
    end
    if (pae) m_paused = !m_paused;
    m_nq = nb; m_pq = pb; m_paq = pa; m_after_rst = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc(input bit r, input bit t, input bit nb, input bit pb,
                     input bit pa = 1'b0);
    @(negedge clk);
    rst_n = r; tick = t; next_btn = nb; prev_btn = pb;
`ifdef ANI_SEQUENCER_PAUSE_EN
    pause_btn = pa;
`endif
    #1;
    model_update(r, t, nb, pb, pa);
    @(posedge clk);
    #1;
    chk("anim1",  int'(anim1),  m_anim[0]);
    chk("frame1", int'(frame1), m_frame[0]);
    chk("step1",  int'(step1),  m_step[0]);
    chk("wrap1",  int'(wrap1),  m_wrap[0]);
    chk("anim4",  int'(anim4),  m_anim[1]);
    chk("frame4", int'(frame4), m_frame[1]);
    chk("step4",  int'(step4),  m_step[1]);
    chk("wrap4",  int'(wrap4),  m_wrap[1]);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
  endtask

  typedef struct {
    bit t, nb, pb;
    int anim, frame;
    bit step, wrap;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int steps, wraps;
    bit rt, rnb, rpb, rpa;

    rst_n = 0; tick = 0; next_btn = 0; prev_btn = 0; auto_en = 0;
    lim_fix = 5'd10; lim_mode = 0;
`ifdef ANI_SEQUENCER_PAUSE_EN
    pause_btn = 0;
`endif

    // Expected dut1 outputs with TICK_DIV=1, limit=10, auto_en=0.
    for (int i = 0; i < 9; i++) tbl[i] = '{1, 0, 0, 0, i + 1, 1, 0};
    tbl[9]  = '{1, 0, 0, 0, 0, 1, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 1, 63, 0, 0, 0};
    tbl[12] = '{0, 1, 0, 0, 0, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 1, 1, 0};

    do_reset();
    chk("rst_anim4", int'(anim4), 5);
    chk("rst_frame1", int'(frame1), 0);
    for (int i = 0; i < 14; i++) begin
      cyc(1, tbl[i].t, tbl[i].nb, tbl[i].pb);
      chk($sformatf("tbl%0d_anim", i),  int'(anim1),  tbl[i].anim);
      chk($sformatf("tbl%0d_frame", i), int'(frame1), tbl[i].frame);
      chk($sformatf("tbl%0d_step", i),  int'(step1),  int'(tbl[i].step));
      chk($sformatf("tbl%0d_wrap", i),  int'(wrap1),  int'(tbl[i].wrap));
    end

    // limit=0 means 32 frames; the wrap advances the animation when auto_en=1.
    lim_fix = 5'd0; auto_en = 1;
    do_reset();
    for (int i = 0; i < 31; i++) cyc(1, 1, 0, 0);
    chk("len32_frame31", int'(frame1), 31);
    cyc(1, 1, 0, 0);
    chk("len32_frame0", int'(frame1), 0);
    chk("len32_wrap", int'(wrap1), 1);
    chk("len32_anim", int'(anim1), 1);

    // A button edge on the wrap tick wins, and no auto advance is applied.
    lim_fix = 5'd3;
    do_reset();
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("prio_pre_frame", int'(frame1), 2);
    cyc(1, 1, 1, 0);
    chk("prio_anim", int'(anim1), 1);
    chk("prio_frame", int'(frame1), 0);
    chk("prio_wrap", int'(wrap1), 0);
    chk("prio_step", int'(step1), 0);
    cyc(1, 0, 0, 0);

    // TICK_DIV=4 with limit=2. Coincident next and prev edges cancel.
    lim_fix = 5'd2; auto_en = 0;
    do_reset();
    steps = 0; wraps = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 0, 0);
      steps += int'(step4);
      wraps += int'(wrap4);
    end
    chk("div4_steps", steps, 2);
    chk("div4_wraps", wraps, 1);
    cyc(1, 1, 1, 1);
    chk("both_anim4", int'(anim4), 5);
    chk("both_anim1", int'(anim1), 0);
    cyc(1, 0, 0, 0);

    // A button held through reset release produces no edge.
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    chk("held_anim1", int'(anim1), 0);
    chk("held_anim4", int'(anim4), 5);
    cyc(1, 0, 0, 0);

`ifdef ANI_SEQUENCER_PAUSE_EN
    lim_fix = 5'd10;
    do_reset();
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, 0, 1);
      chk("pause_frame", int'(frame1), 0);
      chk("pause_step", int'(step1), 0);
    end
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 1);
    chk("unpause_frame", int'(frame1), 1);
    cyc(1, 0, 0, 0, 0);
`endif

    // Random stimulus, with limit taken from the lookup.
    lim_mode = 1;
    rnb = 0; rpb = 0; rpa = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rt = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) rnb = !rnb;
      if ($urandom_range(0, 7) == 0) rpb = !rpb;
`ifdef ANI_SEQUENCER_PAUSE_EN
      if ($urandom_range(0, 15) == 0) rpa = !rpa;
`endif
      if ($urandom_range(0, 63) == 0) auto_en = !auto_en;
      cyc(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1, rt, rnb, rpb, rpa);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
